// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the
// divider for 115200 baud from the 25 MHz system clock.
package uart_pkg;

  localparam int UART_DATA_BITS               = 8;
  localparam int UART_CLKS_PER_BIT_115200_25M = 217;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. The head entry is always presented on
// pop_data. A push into a full FIFO is accepted only when a pop happens
// in the same cycle. pop_data reads as zero while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; occupancy alone decides what is valid,
  // and leaving it out keeps the storage mappable to plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling and a byte FIFO behind a
// valid/ready interface. Framing errors and overruns are one-cycle pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200_25M,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] RELOAD   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

  rx_state_e                 state;
  logic                      rx_meta;
  logic                      rx_s;
  logic [CW-1:0]             cnt;
  logic [BW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      tick;
  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push_ok;

  assign tick    = (cnt == '0);
  assign push    = (state == STOP) && tick && rx_s;
  assign pop     = valid & ready;
  assign push_ok = ~fifo_full | pop;
  assign valid   = ~fifo_empty;

  // Two-flop synchroniser for the asynchronous pin; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame recovery: bit timer, state machine, shift register, error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // NOTE: pulses default low here and are overridden later in the same
      // block; the last non-blocking assignment to a register wins.
      frame_err <= 1'b0;
      overrun   <= push & ~push_ok;

      if (state == START || state == DATA || state == STOP)
        cnt <= tick ? RELOAD : cnt - 1'b1;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_s) begin
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shift),
    .pop       (pop),
    .pop_data  (data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized bench for uart_rx_fifo with a queue-based model
// of the byte stream and of expected overruns.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int C = 16;
  localparam int D = 4;
  // Cycles from driving the start bit on the pin to the stop-sample cycle.
  localparam int STOP_OFS = 2 + C / 2 + 9 * C;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int fe_seen = 0;
  int ov_seen = 0;
  int exp_ov  = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always @(posedge clk) begin
    if (frame_err === 1'b1) fe_seen++;
    if (overrun === 1'b1)   ov_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      step(C);
    end
  endtask

  // Reference behaviour: a good byte is queued if there is room, else dropped.
  task automatic model_push(input logic [7:0] b);
    if (q.size() < D) q.push_back(b);
    else exp_ov++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s valid%0d", tag, i), valid, 1);
      check($sformatf("%s data%0d", tag, i), data, q[0]);
      ready = 1'b1;
      step(1);
      ready = 1'b0;
      void'(q.pop_front());
    end
    check($sformatf("%s empty", tag), valid, 0);
  endtask

  initial begin
    logic [7:0] b;
    logic [9:0] bits;
    int fe0;
    int n;

    rx = 1'b1;
    ready = 1'b0;
    reset = 1'b1;
    step(3);
    check("reset valid", valid, 0);
    check("reset data", data, 8'h00);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    check("reset state", dut.state, IDLE);
    reset = 1'b0;
    step(C);

    // 1: single byte, valid timing, one-cycle pop
    fork
      send_frame(8'hA5, 1'b1);
      begin
        step(STOP_OFS);
        check("t1 valid at stop sample", valid, 0);
        step(1);
        check("t1 valid rise", valid, 1);
        check("t1 data", data, 8'hA5);
      end
    join
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("t1 valid after pop", valid, 0);

    // 2: back-to-back frames overflow a 4-deep FIFO
    send_frame(8'h00, 1'b1); model_push(8'h00);
    send_frame(8'hFF, 1'b1); model_push(8'hFF);
    send_frame(8'h55, 1'b1); model_push(8'h55);
    send_frame(8'h3C, 1'b1); model_push(8'h3C);
    fork
      send_frame(8'h81, 1'b1);
      begin
        step(STOP_OFS);
        check("t2 overrun before", overrun, 0);
        step(1);
        check("t2 overrun pulse", overrun, 1);
        step(1);
        check("t2 overrun after", overrun, 0);
      end
    join
    model_push(8'h81);
    check("t2 overrun count", ov_seen, exp_ov);
    drain("t2");

    // 3: framing error followed by a long break, then a clean byte
    fe0 = fe_seen;
    fork
      send_frame(8'h42, 1'b0);
      begin
        step(STOP_OFS + 1);
        check("t3 frame_err pulse", frame_err, 1);
        step(1);
        check("t3 frame_err after", frame_err, 0);
      end
    join
    rx = 1'b0;
    step(40 * C);
    check("t3 state in break", dut.state, WAIT_HIGH);
    check("t3 frame_err count", fe_seen - fe0, 1);
    check("t3 no push", valid, 0);
    rx = 1'b1;
    step(C);
    send_frame(8'h17, 1'b1);
    model_push(8'h17);
    drain("t3");

    // 4: a 3-cycle glitch must not start a frame
    fe0 = fe_seen;
    rx = 1'b0;
    step(3);
    rx = 1'b1;
    step(2);
    check("t4 state start", dut.state, START);
    step(6);
    check("t4 state idle", dut.state, IDLE);
    step(2 * C);
    check("t4 no valid", valid, 0);
    check("t4 no frame_err", fe_seen - fe0, 0);

    // 5: full FIFO with a pop coinciding with the fifth stop sample
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom());
      send_frame(b, 1'b1);
      model_push(b);
    end
    b = 8'($urandom());
    fork
      send_frame(b, 1'b1);
      begin
        step(STOP_OFS);
        ready = 1'b1;
        check("t5 popped head", data, q[0]);
        step(1);
        ready = 1'b0;
      end
    join
    void'(q.pop_front());
    model_push(b);
    check("t5 overrun count", ov_seen, exp_ov);
    drain("t5");

    // 6: reset during data bit 4 with two bytes queued
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom());
      send_frame(b, 1'b1);
      model_push(b);
    end
    check("t6 queued", valid, 1);
    bits = {1'b1, 8'h99, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = bits[i];
      step(C);
    end
    rx = bits[5];
    step(8);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t6 valid after reset", valid, 0);
    check("t6 data after reset", data, 8'h00);
    q.delete();
    fe0 = fe_seen;
    rx = 1'b1;
    step(12 * C);
    check("t6 no aborted byte", valid, 0);
    check("t6 no frame_err", fe_seen - fe0, 0);
    send_frame(8'h24, 1'b1);
    model_push(8'h24);
    drain("t6");

    // 7: random bursts of back-to-back bytes
    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom());
        send_frame(b, 1'b1);
        model_push(b);
      end
      step(2);
      check($sformatf("t7 overrun count r%0d", r), ov_seen, exp_ov);
      drain($sformatf("t7 r%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
